// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port unified memory between the instruction fetch
//   path and the load/store path. Every access is a req/ack transaction on
//   the memory side. Data accesses take priority over fetches, and a streak
//   counter forces a pending fetch through after STARVE_MAX back-to-back
//   data grants. An optional timeout aborts a grant that never sees an ack.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-low reset
//   if_req_i/if_addr_i      fetch request (level) and address
//   if_data_o/if_ready_o    fetched instruction, fetch complete
//   dm_read_i/dm_write_i    load / store requests (level), both high = store
//   dm_addr_i/dm_wdata_i    load/store address, store data
//   dm_rdata_o/dm_ready_o   load data, load/store complete
//   err_o                   current completion was a timeout abort
//   stall_o                 pipeline-wide stall
//   mem_req_o/mem_we_o      memory request / write enable
//   mem_addr_o/mem_wdata_o  memory address / write data
//   mem_rdata_i/mem_ack_i   memory read data / one-cycle completion pulse

module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ready_o,
    input  logic              dm_read_i,
    input  logic              dm_write_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ready_o,
    output logic              err_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT_I = 2'd1;
    localparam logic [1:0] GRANT_D = 2'd2;

    localparam int unsigned SW   = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam int unsigned TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    logic [1:0]        state;
    logic              if_done;
    logic              dm_done;
    logic [DATA_W-1:0] if_data;
    logic [DATA_W-1:0] dm_rdata;
    logic [SW-1:0]     streak;
    logic [TW-1:0]     tcnt;
    logic              err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    logic dm_req;
    logic if_pend;
    logic dm_pend;
    logic stall;
    logic starved;
    logic timeout_hit;

    always_comb begin
        dm_req  = dm_read_i | dm_write_i;
        if_pend = if_req_i & ~if_done;
        dm_pend = dm_req & ~dm_done;
        // Gated by reset so the stall releases the instant reset asserts,
        // even though requesters may still be holding their requests.
        stall   = rst_i & (if_pend | dm_pend);
        starved = if_pend & (streak == SW'(STARVE_MAX));
        // The grant cycle count starts at 0 on entry, so the abort edge is
        // the one closing the TIMEOUT-th cycle of mem_req_o.
        timeout_hit = (TIMEOUT > 0) && (tcnt == TW'(TLIM));
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
            if_data   <= '0;
            dm_rdata  <= '0;
            streak    <= '0;
            tcnt      <= '0;
            err       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            err <= 1'b0;
            // Pipeline advances: retire both completions. A completion
            // assigned below in the same cycle takes precedence.
            if (!stall) begin
                if_done <= 1'b0;
                dm_done <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (dm_pend && !starved) begin
                        state     <= GRANT_D;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_write_i;
                        mem_addr  <= dm_addr_i;
                        mem_wdata <= dm_wdata_i;
                        tcnt      <= '0;
                        if (!if_pend)
                            streak <= '0;
                        else if (streak != SW'(STARVE_MAX))
                            streak <= streak + 1'b1;
                    end else if (if_pend) begin
                        state     <= GRANT_I;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr_i;
                        mem_wdata <= '0;
                        tcnt      <= '0;
                        streak    <= '0;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (mem_ack_i) begin
                        if (state == GRANT_I) begin
                            if_data <= mem_rdata_i;
                            if_done <= 1'b1;
                        end else begin
                            if (!mem_we)
                                dm_rdata <= mem_rdata_i;
                            dm_done <= 1'b1;
                        end
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= IDLE;
                    end else if (timeout_hit) begin
                        if (state == GRANT_I) begin
                            if_data <= '0;
                            if_done <= 1'b1;
                        end else begin
                            dm_rdata <= '0;
                            dm_done  <= 1'b1;
                        end
                        err     <= 1'b1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign if_data_o   = if_data;
    assign if_ready_o  = if_done;
    assign dm_rdata_o  = dm_rdata;
    assign dm_ready_o  = dm_done;
    assign err_o       = err;
    assign stall_o     = stall;
    assign mem_req_o   = mem_req;
    assign mem_we_o    = mem_we;
    assign mem_addr_o  = mem_addr;
    assign mem_wdata_o = mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter (STARVE_MAX=4, TIMEOUT=8). The
//   memory side is driven by hand with fixed ack timing; every expected
//   value is written out as a constant worked from the cycle-level
//   behaviour of the arbiter.

module tb_mem_port_arbiter;

    logic        clk_i;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_ready_o;
    logic        dm_read_i;
    logic        dm_write_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [31:0] dm_rdata_o;
    logic        dm_ready_o;
    logic        err_o;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (4),
        .TIMEOUT    (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_data_o   (if_data_o),
        .if_ready_o  (if_ready_o),
        .dm_read_i   (dm_read_i),
        .dm_write_i  (dm_write_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_rdata_o  (dm_rdata_o),
        .dm_ready_o  (dm_ready_o),
        .err_o       (err_o),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b0; if_req_i = 1'b0; if_addr_i = '0;
        dm_read_i = 1'b0; dm_write_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
        mem_rdata_i = '0; mem_ack_i = 1'b0;

        // Reset state
        step(); step();
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_stall",   32'(stall_o),   32'd0);
        chk("rst_if_rdy",  32'(if_ready_o), 32'd0);
        chk("rst_dm_rdy",  32'(dm_ready_o), 32'd0);
        chk("rst_err",     32'(err_o),     32'd0);
        chk("rst_if_data", if_data_o,      32'd0);
        chk("rst_dm_data", dm_rdata_o,     32'd0);
        rst_i = 1'b1;
        step();

        // 1. Fetch only
        if_req_i = 1'b1; if_addr_i = 32'h40;
        #1 chk("t1_stall_T", 32'(stall_o), 32'd1);
        chk("t1_req_T", 32'(mem_req_o), 32'd0);
        step();
        chk("t1_req_T1",  32'(mem_req_o), 32'd1);
        chk("t1_addr",    mem_addr_o,     32'h40);
        chk("t1_we",      32'(mem_we_o),  32'd0);
        chk("t1_stall_T1", 32'(stall_o),  32'd1);
        step();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h8C020004;
        chk("t1_stall_T2", 32'(stall_o),   32'd1);
        chk("t1_rdy_T2",   32'(if_ready_o), 32'd0);
        step();
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        chk("t1_rdy_T3",   32'(if_ready_o), 32'd1);
        chk("t1_data_T3",  if_data_o,       32'h8C020004);
        chk("t1_stall_T3", 32'(stall_o),    32'd0);
        chk("t1_req_T3",   32'(mem_req_o),  32'd0);
        if_req_i = 1'b0;
        step();
        chk("t1_rdy_clr",  32'(if_ready_o), 32'd0);
        chk("t1_data_hold", if_data_o,      32'h8C020004);

        // 2. Simultaneous load and fetch: load first
        dm_read_i = 1'b1; dm_addr_i = 32'h100; if_req_i = 1'b1; if_addr_i = 32'h44;
        step();
        chk("t2_req_d",  32'(mem_req_o), 32'd1);
        chk("t2_addr_d", mem_addr_o,     32'h100);
        chk("t2_we_d",   32'(mem_we_o),  32'd0);
        mem_ack_i = 1'b1; mem_rdata_i = 32'hAAAA5555;
        step();
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        chk("t2_dm_rdy",   32'(dm_ready_o), 32'd1);
        chk("t2_dm_data",  dm_rdata_o,      32'hAAAA5555);
        chk("t2_stall_mid", 32'(stall_o),   32'd1);
        step();
        chk("t2_req_i",  32'(mem_req_o), 32'd1);
        chk("t2_addr_i", mem_addr_o,     32'h44);
        chk("t2_stall_i", 32'(stall_o),  32'd1);
        chk("t2_dm_hold", dm_rdata_o,    32'hAAAA5555);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h11112222;
        step();
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        chk("t2_if_rdy",  32'(if_ready_o), 32'd1);
        chk("t2_if_data", if_data_o,       32'h11112222);
        chk("t2_dm_rdy2", 32'(dm_ready_o), 32'd1);
        chk("t2_stall_end", 32'(stall_o),  32'd0);
        chk("t2_dm_hold2", dm_rdata_o,     32'hAAAA5555);
        dm_read_i = 1'b0; if_req_i = 1'b0;
        step();

        // 3. Store, then store with read also asserted
        dm_write_i = 1'b1; dm_addr_i = 32'h20; dm_wdata_i = 32'h12345678;
        step();
        chk("t3_we",    32'(mem_we_o), 32'd1);
        chk("t3_wdata", mem_wdata_o,   32'h12345678);
        chk("t3_addr",  mem_addr_o,    32'h20);
        mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        step();
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        chk("t3_dm_rdy",  32'(dm_ready_o), 32'd1);
        chk("t3_dm_hold", dm_rdata_o,      32'hAAAA5555);
        chk("t3_we_clr",  32'(mem_we_o),   32'd0);
        chk("t3_stall",   32'(stall_o),    32'd0);
        dm_write_i = 1'b0;
        step();
        dm_read_i = 1'b1; dm_write_i = 1'b1; dm_addr_i = 32'h24; dm_wdata_i = 32'hCAFEF00D;
        step();
        chk("t3b_we",    32'(mem_we_o), 32'd1);
        chk("t3b_wdata", mem_wdata_o,   32'hCAFEF00D);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h0BADF00D;
        step();
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        chk("t3b_dm_hold", dm_rdata_o, 32'hAAAA5555);
        dm_read_i = 1'b0; dm_write_i = 1'b0;
        step();

        // 4. Starvation. The fetch request is dropped only in the cycle the
        // load completes, so the pipeline can advance and the next load can
        // start a fresh transaction while the fetch is still outstanding.
        for (int i = 1; i <= 4; i++) begin
            if_req_i = 1'b1; if_addr_i = 32'h48;
            dm_read_i = 1'b1; dm_addr_i = 32'h200 + 32'(4 * i);
            step();
            chk("t4_addr_d", mem_addr_o, 32'h200 + 32'(4 * i));
            chk("t4_streak", 32'(dut.streak), 32'(i));
            mem_ack_i = 1'b1; mem_rdata_i = 32'(i);
            step();
            mem_ack_i = 1'b0; mem_rdata_i = '0;
            chk("t4_dm_rdy", 32'(dm_ready_o), 32'd1);
            if_req_i = 1'b0; dm_read_i = 1'b0;
            #1 chk("t4_adv", 32'(stall_o), 32'd0);
            step();
        end
        if_req_i = 1'b1; if_addr_i = 32'h48; dm_read_i = 1'b1; dm_addr_i = 32'h300;
        step();
        chk("t4_forced_addr", mem_addr_o,       32'h48);
        chk("t4_forced_we",   32'(mem_we_o),    32'd0);
        chk("t4_streak_rst",  32'(dut.streak),  32'd0);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h0000ABCD;
        step();
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        chk("t4_if_rdy", 32'(if_ready_o), 32'd1);
        chk("t4_if_data", if_data_o,      32'h0000ABCD);
        chk("t4_dm_wait", 32'(dm_ready_o), 32'd0);
        step();
        chk("t4_addr_d2", mem_addr_o, 32'h300);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h00003300;
        step();
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        chk("t4_dm_rdy2", 32'(dm_ready_o), 32'd1);
        chk("t4_stall_end", 32'(stall_o),  32'd0);
        if_req_i = 1'b0; dm_read_i = 1'b0;
        step();

        // 5. Timeout after 8 cycles of mem_req_o
        dm_read_i = 1'b1; dm_addr_i = 32'h80;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("t5_req_held", 32'(mem_req_o), 32'd1);
        end
        step();
        chk("t5_req_drop", 32'(mem_req_o),  32'd0);
        chk("t5_dm_rdy",   32'(dm_ready_o), 32'd1);
        chk("t5_err",      32'(err_o),      32'd1);
        chk("t5_dm_zero",  dm_rdata_o,      32'd0);
        dm_read_i = 1'b0;
        step();
        chk("t5_err_pulse", 32'(err_o),     32'd0);
        chk("t5_rdy_clr",   32'(dm_ready_o), 32'd0);

        // 6. Reset mid GRANT_D, late ack afterwards
        dm_read_i = 1'b1; dm_addr_i = 32'h90;
        step();
        chk("t6_req", 32'(mem_req_o), 32'd1);
        #2 rst_i = 1'b0;
        #1 chk("t6_req_async",   32'(mem_req_o), 32'd0);
        chk("t6_stall_async", 32'(stall_o),      32'd0);
        dm_read_i = 1'b0;
        step();
        rst_i = 1'b1;
        step();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h55555555;
        step();
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        chk("t6_late_rdy",  32'(dm_ready_o), 32'd0);
        chk("t6_late_data", dm_rdata_o,      32'd0);
        chk("t6_late_req",  32'(mem_req_o),  32'd0);
        chk("t6_state",     32'(dut.state),  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
